// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single synchronous data-memory port (1-cycle read latency).
// Round-robin between CPU (requester 0) and loader (requester 1), with bounded burst locking.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  // Requester 0: CPU load/store path
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  // Requester 1: loader / debug DMA
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  // Shared read data and CPU stall
  output logic [31:0]       rdata,
  output logic              stall_cpu,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] BurstLimit = 8'(MAX_BURST - 1);
  localparam logic [7:0] BurstMax   = 8'hFF;

  logic       last_q, last_d;
  logic       owner_valid_q, owner_valid_d;
  logic       owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pend0_q, rd_pend0_d;
  logic       rd_pend1_q, rd_pend1_d;

  logic gnt0_c, gnt1_c;
  logic limit_hit;
  logic any_gnt;
  logic win_id;
  logic win_lock;

  // Grant decision: locked owner first (unless forced out), then sole requester, then round-robin.
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    limit_hit = (burst_cnt_q >= BurstLimit);
    if (!reset) begin
      if (owner_valid_q && !owner_q && req0 && !(req1 && limit_hit)) begin
        gnt0_c = 1'b1;
      end else if (owner_valid_q && owner_q && req1 && !(req0 && limit_hit)) begin
        gnt1_c = 1'b1;
      end else if (req0 && !req1) begin
        gnt0_c = 1'b1;
      end else if (req1 && !req0) begin
        gnt1_c = 1'b1;
      end else if (req0 && req1) begin
        if (last_q) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0_c) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1_c) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign any_gnt  = gnt0_c | gnt1_c;
  assign win_id   = gnt1_c;
  assign win_lock = gnt1_c ? lock1 : lock0;

  always_comb begin
    last_d        = last_q;
    owner_valid_d = 1'b0;
    owner_d       = owner_q;
    burst_cnt_d   = 8'd0;
    if (any_gnt) begin
      last_d = win_id;
      if (win_lock) begin
        owner_valid_d = 1'b1;
        owner_d       = win_id;
        if (owner_valid_q && (owner_q == win_id)) begin
          burst_cnt_d = (burst_cnt_q == BurstMax) ? BurstMax : burst_cnt_q + 8'd1;
        end else begin
          burst_cnt_d = 8'd1;
        end
      end
    end
    rd_pend0_d = gnt0_c & ~we0;
    rd_pend1_d = gnt1_c & ~we1;
  end

  // last resets to 1 so the CPU wins the first contested cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q        <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      burst_cnt_q   <= 8'd0;
      rd_pend0_q    <= 1'b0;
      rd_pend1_q    <= 1'b0;
    end else begin
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      rd_pend0_q    <= rd_pend0_d;
      rd_pend1_q    <= rd_pend1_d;
    end
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign mem_en    = any_gnt;
  assign rvalid0   = rd_pend0_q;
  assign rvalid1   = rd_pend1_q;
  assign rdata     = mem_rdata;
  assign stall_cpu = req0 & ~gnt0_c & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-feature tasks plus a read-data scoreboard.
module tb_dmem_arbiter;

  localparam int unsigned AW  = 14;
  localparam int unsigned MB  = 8;
  localparam int          Lim = MB - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall_cpu, mem_en, mem_we;
  logic [31:0]   rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'h0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .stall_cpu(stall_cpu),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return (a == AW'(16)) ? 32'hDEADBEEF : {16'hC0DE, 2'b00, a};
  endfunction

  // Memory model: synchronous read, one cycle of latency.
  always @(posedge clock) begin
    if (mem_en && !mem_we) mem_rdata <= mem_fn(mem_addr);
  end

  // Scoreboard: pop on rvalid, push on a granted read (expected data from the bench's address).
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (rvalid0 && rvalid1) begin
        errors++;
        $display("FAIL rvalid_both: rvalid0=%b rvalid1=%b, required not both", rvalid0, rvalid1);
      end
      if (rvalid0 || rvalid1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rvalid0=%b rvalid1=%b with no read outstanding",
                   rvalid0, rvalid1);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (rvalid1 !== e.id || rdata !== e.data) begin
            errors++;
            $display("FAIL sb_rdata: got id=%0d data=%h, required id=%0d data=%h",
                     rvalid1, rdata, e.id, e.data);
          end
        end
      end
      if (gnt0 && !we0) sb.push_back({1'b0, mem_fn(addr0)});
      if (gnt1 && !we1) sb.push_back({1'b1, mem_fn(addr1)});
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    idle();
    obs = {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, stall_cpu};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000", obs);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, AW'(16), '0, 1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if ({gnt0, gnt1, mem_en, mem_we, stall_cpu} !== 5'b10100 || mem_addr !== AW'(16)) begin
      errors++;
      $display("FAIL single_grant: gnt0/gnt1/en/we/stall=%b addr=%h, required 10100 addr=010",
               {gnt0, gnt1, mem_en, mem_we, stall_cpu}, mem_addr);
    end
    tick();
    idle();
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEADBEEF || stall_cpu !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid: rvalid0=%b rvalid1=%b rdata=%h stall=%b, required 1 0 deadbeef 0",
               rvalid0, rvalid1, rdata, stall_cpu);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic e0;
      e0 = ((c % 2) == 0);
      drive(1'b1, 1'b0, 1'b0, AW'(32), '0, 1'b1, 1'b0, 1'b0, AW'(48), '0);
      checks++;
      if (gnt0 !== e0 || gnt1 !== !e0 || stall_cpu !== !e0 || rvalid0 !== (c % 2 == 1)
          || rvalid1 !== (c > 0 && c % 2 == 0) || mem_addr !== (e0 ? AW'(32) : AW'(48))) begin
        errors++;
        $display("FAIL rr_cycle%0d: g0=%b g1=%b stall=%b rv0=%b rv1=%b addr=%h, required g0=%b",
                 c, gnt0, gnt1, stall_cpu, rvalid0, rvalid1, mem_addr, e0);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_burst_release();
    do_reset();
    for (int c = 0; c <= Lim + 1; c++) begin
      logic r0, e1;
      r0 = (c >= 2 && c <= Lim);
      e1 = (c != Lim);
      drive(r0, 1'b0, 1'b0, AW'(64), '0, 1'b1, 1'b1, 1'b1, AW'(c), 32'h1000 + c);
      checks++;
      if (gnt1 !== e1 || gnt0 !== !e1 || stall_cpu !== (c >= 2 && c < Lim) || mem_we !== e1
          || (e1 && (mem_addr !== AW'(c) || mem_wdata !== 32'h1000 + c))) begin
        errors++;
        $display("FAIL burst_cycle%0d: g0=%b g1=%b stall=%b we=%b addr=%h wd=%h, required g1=%b",
                 c, gnt0, gnt1, stall_cpu, mem_we, mem_addr, mem_wdata, e1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, AW'(c), 32'(c));
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || rvalid0 !== 1'b0
          || rvalid1 !== 1'b0) begin
        errors++;
        $display("FAIL solo_lock_cycle%0d: g0=%b g1=%b we=%b rv0=%b rv1=%b, required 0 1 1 0 0",
                 c, gnt0, gnt1, mem_we, rvalid0, rvalid1);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, AW'(80), '0, 1'b1, 1'b1, 1'b1, AW'(20), 32'd20);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL long_burst_release: g0=%b g1=%b, required 1 0", gnt0, gnt1);
    end
    tick();
    idle();
  endtask

  task automatic test_idle_release();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, AW'(96), '0);
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL idle_setup: g1=%b, required 1", gnt1);
    end
    tick();
    // Junk on the qualifying inputs must be ignored while req is low.
    drive(1'b0, 1'b1, 1'b1, '1, '1, 1'b0, 1'b1, 1'b1, '1, '1);
    checks++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL idle_outputs: g0/g1/en/we=%b addr=%h wd=%h, required 0000 0 0",
               {gnt0, gnt1, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, AW'(100), '0, 1'b1, 1'b0, 1'b1, AW'(101), '0);
      checks++;
      if (gnt0 !== (c == 0) || gnt1 !== (c == 1)) begin
        errors++;
        $display("FAIL post_idle_rr%0d: g0=%b g1=%b, required g0=%b", c, gnt0, gnt1, c == 0);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, AW'(c), 32'(c));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, AW'(112), '0);
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_grant: g1=%b, required 1", gnt1);
    end
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (gnt1 !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_gates_grant: g1=%b en=%b, required 0 0", gnt1, mem_en);
    end
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if (rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL stale_rvalid: rvalid1=%b, required 0", rvalid1);
    end
    drive(1'b1, 1'b0, 1'b0, AW'(113), '0, 1'b1, 1'b0, 1'b0, AW'(114), '0);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: g0=%b g1=%b, required 1 0", gnt0, gnt1);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, AW'(115), '0);
    tick();
    idle();
    checks++;
    if (rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL pend_before_reset: rvalid1=%b, required 1", rvalid1);
    end
    reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL async_cancel: rvalid1=%b, required 0", rvalid1);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_release();
    test_saturate();
    test_idle_release();
    test_reset_mid_read();
    do_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d reads never returned, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
